// File: rtl/fb_scanout_axis_src_if.sv
// Bus bundle for the framebuffer scanout source: AXI4 read channels (AR/R) and the
// AXI-Stream pixel output, with master (scanout block) and slave (memory/sink) views.
interface fb_scanout_axis_src_if #(
    parameter int unsigned ADDR_WIDTH = 28,
    parameter int unsigned ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [63:0]           m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;
    logic [23:0]           m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tuser;
    logic                  m_axis_tready;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready
    );
endinterface

// File: rtl/fb_scanout_axis_src.sv
// Framebuffer scanout: credit-limited AXI4 burst reader feeding a beat FIFO, unpacked into
// one frame of 24-bit RGB pixels (two per 64-bit beat, low word first) on AXI-Stream.
module fb_scanout_axis_src #(
    parameter int unsigned SCREEN_WIDTH  = 480,
    parameter int unsigned SCREEN_HEIGHT = 360,
    parameter int unsigned ADDR_WIDTH    = 28,
    parameter int unsigned ID_WIDTH      = 4,
    parameter int unsigned AXI_ID        = 0,
    parameter int unsigned BURST_LEN     = 16,
    parameter int unsigned FIFO_DEPTH    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  rresp_err,
    fb_scanout_axis_src_if.master bus
);
    localparam int unsigned TOTAL_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int unsigned TOTAL_BEATS  = TOTAL_PIXELS / 2;
    localparam int unsigned CNT_MAX      = (TOTAL_BEATS > FIFO_DEPTH) ? TOTAL_BEATS : FIFO_DEPTH;
    localparam int unsigned CW           = $clog2(CNT_MAX + 1);
    localparam int unsigned PW           = (TOTAL_PIXELS > 2) ? $clog2(TOTAL_PIXELS) : 1;
    localparam int unsigned AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         req_left_q;
    logic [CW-1:0]         outstanding_q;
    logic [CW-1:0]         fifo_cnt_q;
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic                  half_q;
    logic [PW-1:0]         pixel_cnt_q;
    logic                  err_q;
    logic [47:0]           mem [2**AW];

    logic [CW-1:0] burst;
    logic [CW-1:0] credit;
    logic [47:0]   head;
    logic          ar_hs;
    logic          r_hs;
    logic          px_hs;
    logic          pop;
    logic          last_px;
    logic          unused_bits;

    assign unused_bits = ^{bus.m_axi_rid, bus.m_axi_rlast, bus.m_axi_rdata[63:56],
                           bus.m_axi_rdata[31:24]};

    assign bus.m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign bus.m_axi_arsize  = 3'd3;
    assign bus.m_axi_arburst = 2'd1;

    always_comb begin
        burst  = (req_left_q > CW'(BURST_LEN)) ? CW'(BURST_LEN) : req_left_q;
        // Free slots not already promised to in-flight beats; only an AR handshake lowers it.
        credit = CW'(FIFO_DEPTH) - fifo_cnt_q - outstanding_q;
        head   = mem[rd_ptr_q];

        bus.m_axi_arvalid = (state_q == StRun) && (req_left_q != '0) && (credit >= burst);
        bus.m_axi_araddr  = addr_q;
        bus.m_axi_arlen   = (req_left_q != '0) ? 8'(burst - CW'(1)) : 8'd0;
        bus.m_axi_rready  = (state_q != StIdle) && (outstanding_q != '0);

        bus.m_axis_tvalid = ((state_q == StRun) || (state_q == StDrain)) && (fifo_cnt_q != '0);
        bus.m_axis_tdata  = '0;
        if (bus.m_axis_tvalid) begin
            bus.m_axis_tdata = half_q ? head[47:24] : head[23:0];
        end
        bus.m_axis_tuser = bus.m_axis_tvalid && (pixel_cnt_q == '0);
        bus.m_axis_tlast = bus.m_axis_tvalid && (pixel_cnt_q == PW'(TOTAL_PIXELS - 1));

        ar_hs   = bus.m_axi_arvalid && bus.m_axi_arready;
        r_hs    = bus.m_axi_rready && bus.m_axi_rvalid;
        px_hs   = bus.m_axis_tvalid && bus.m_axis_tready;
        pop     = px_hs && half_q;
        last_px = px_hs && (pixel_cnt_q == PW'(TOTAL_PIXELS - 1));

        busy       = (state_q != StIdle);
        frame_done = (state_q == StDone);
        rresp_err  = err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            req_left_q    <= '0;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            half_q        <= 1'b0;
            pixel_cnt_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q    <= StRun;
                        addr_q     <= {base_addr[ADDR_WIDTH-1:3], 3'b000};
                        req_left_q <= CW'(TOTAL_BEATS);
                        err_q      <= 1'b0;
                    end
                end
                StRun:   if (ar_hs && (req_left_q == burst)) state_q <= StDrain;
                StDrain: if (last_px) state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            if (ar_hs) begin
                addr_q     <= addr_q + (ADDR_WIDTH'(burst) << 3);
                req_left_q <= req_left_q - burst;
            end
            outstanding_q <= outstanding_q + (ar_hs ? burst : CW'(0)) - CW'(r_hs);

            if (r_hs) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (bus.m_axi_rresp != 2'b00) err_q <= 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            fifo_cnt_q <= fifo_cnt_q + CW'(r_hs) - CW'(pop);

            if (px_hs) begin
                half_q      <= ~half_q;
                pixel_cnt_q <= last_px ? '0 : pixel_cnt_q + PW'(1);
            end
        end
    end

    // Only the two RGB fields of each beat are kept.
    always_ff @(posedge clk) begin
        if (r_hs) mem[wr_ptr_q] <= {bus.m_axi_rdata[55:32], bus.m_axi_rdata[23:0]};
    end
endmodule

// File: tb/tb_fb_scanout_axis_src.sv
// Randomized bench for fb_scanout_axis_src: behavioural memory slave and sink, with a
// frame-level reference model of expected bursts, pixels and flow-control rules.
module tb_fb_scanout_axis_src;
    localparam int unsigned W    = 6;
    localparam int unsigned H    = 3;
    localparam int unsigned AW   = 28;
    localparam int unsigned IDW  = 4;
    localparam int unsigned BL   = 2;
    localparam int unsigned FD   = 4;
    localparam int          NPIX = W * H;
    localparam int          NBEATS = NPIX / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, frame_done, rresp_err;

    fb_scanout_axis_src_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IDW)) bus_if ();

    fb_scanout_axis_src #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_WIDTH(AW), .ID_WIDTH(IDW),
        .AXI_ID(0), .BURST_LEN(BL), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy),
        .frame_done(frame_done), .rresp_err(rresp_err), .bus(bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [23:0] seed;

    logic [23:0]   got_pix[$];
    bit            got_user[$];
    bit            got_last[$];
    logic [AW-1:0] got_ar_addr[$];
    logic [7:0]    got_ar_len[$];
    int            viol;
    string         viol_msg;
    int            first_ar_cyc, done_cyc, last_hs_cyc;
    bit            timed_out;
    logic          done_err;

    function automatic logic [63:0] beat_fn(input logic [AW-1:0] a);
        logic [23:0] lo, hi;
        lo = 24'(a * 7) ^ seed;
        hi = 24'(a * 13) + seed;
        return {8'hC3, hi, 8'h3C, lo};
    endfunction

    function automatic int pix_mism(input logic [AW-1:0] base, output string msg);
        int bad;
        logic [AW-1:0] a;
        logic [63:0] d;
        logic [23:0] e;
        bad = 0;
        msg = "";
        if (got_pix.size() != NPIX) begin
            msg = $sformatf("pixel count %0d want %0d", got_pix.size(), NPIX);
            return 1;
        end
        for (int k = 0; k < NPIX; k++) begin
            a = {base[AW-1:3], 3'b000} + AW'(8 * (k / 2));
            d = beat_fn(a);
            e = (k % 2 == 0) ? d[23:0] : d[55:32];
            if (got_pix[k] !== e || got_user[k] !== (k == 0) || got_last[k] !== (k == NPIX - 1)) begin
                bad++;
                if (msg == "") msg = $sformatf("pixel %0d got %h/u%0b/l%0b want %h/u%0b/l%0b", k,
                    got_pix[k], got_user[k], got_last[k], e, k == 0, k == NPIX - 1);
            end
        end
        return bad;
    endfunction

    function automatic int ar_mism(input logic [AW-1:0] base, output string msg);
        int bad, left, b, n;
        logic [AW-1:0] a;
        bad = 0; n = 0; msg = "";
        left = NBEATS;
        a = {base[AW-1:3], 3'b000};
        while (left > 0) begin
            b = (left > int'(BL)) ? int'(BL) : left;
            if (n >= got_ar_addr.size()) begin
                msg = $sformatf("missing burst %0d", n);
                return bad + 1;
            end
            if (got_ar_addr[n] !== a || got_ar_len[n] !== 8'(b - 1)) begin
                bad++;
                if (msg == "") msg = $sformatf("burst %0d got %h/len%0d want %h/len%0d", n,
                    got_ar_addr[n], got_ar_len[n], a, b - 1);
            end
            a = a + AW'(8 * b);
            left -= b;
            n++;
        end
        if (got_ar_addr.size() != n) begin
            bad++;
            if (msg == "") msg = $sformatf("burst count %0d want %0d", got_ar_addr.size(), n);
        end
        return bad;
    endfunction

    function automatic void note_viol(input string m);
        viol++;
        if (viol_msg == "") viol_msg = m;
    endfunction

    task automatic drive_idle();
        bus_if.m_axi_arready = 1'b0;
        bus_if.m_axi_rvalid  = 1'b0;
        bus_if.m_axi_rlast   = 1'b0;
        bus_if.m_axi_rresp   = 2'b00;
        bus_if.m_axi_rid     = '0;
        bus_if.m_axi_rdata   = '0;
        bus_if.m_axis_tready = 1'b0;
    endtask

    // Memory slave + sink for one frame; tr_mode 0: always ready, 1: random, 2: one in three.
    task automatic run_frame(input logic [AW-1:0] base, input int tr_mode, input int ar_hold,
                             input int err_beat, input int abort_pix, input bit spam,
                             input bit rnd);
        int occ, outst, rbeat, cyc, npix;
        logic [AW-1:0] rq_addr[$];
        bit rq_last[$];
        bit exp_err, r_pend, ar_hs, r_hs, t_hs;
        logic pv_arvalid, pv_arready, pv_tvalid, pv_tready, pv_tuser, pv_tlast;
        logic [AW-1:0] pv_araddr;
        logic [7:0] pv_arlen;
        logic [23:0] pv_tdata;
        occ = 0; outst = 0; rbeat = 0; cyc = 0; npix = 0;
        exp_err = 1'b0; r_pend = 1'b0;
        pv_arvalid = 1'b0; pv_arready = 1'b0; pv_tvalid = 1'b0; pv_tready = 1'b0;
        pv_tuser = 1'b0; pv_tlast = 1'b0; pv_araddr = '0; pv_arlen = '0; pv_tdata = '0;
        got_pix.delete(); got_user.delete(); got_last.delete();
        got_ar_addr.delete(); got_ar_len.delete();
        viol = 0; viol_msg = ""; first_ar_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
        timed_out = 1'b0; done_err = 1'b0;
        drive_idle();
        base_addr = base;
        start = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (spam && (cyc % 4 == 2)) begin
                start = 1'b1;
                base_addr = AW'($urandom);
            end
            if (cyc > 3000) begin
                timed_out = 1'b1;
                note_viol("cycle budget expired");
                drive_idle();
                break;
            end
            if (busy !== 1'b1) note_viol($sformatf("busy=%b at cycle %0d", busy, cyc));
            if (rresp_err !== exp_err)
                note_viol($sformatf("rresp_err=%b want %b at cycle %0d", rresp_err, exp_err, cyc));
            if (bus_if.m_axi_rready !== (outst > 0))
                note_viol($sformatf("rready=%b with %0d outstanding", bus_if.m_axi_rready, outst));
            if (bus_if.m_axis_tvalid !== (occ > 0))
                note_viol($sformatf("tvalid=%b with %0d beats buffered", bus_if.m_axis_tvalid, occ));
            if (occ > int'(FD)) note_viol($sformatf("FIFO holds %0d beats", occ));
            if (pv_arvalid && !pv_arready && (bus_if.m_axi_arvalid !== 1'b1 ||
                bus_if.m_axi_araddr !== pv_araddr || bus_if.m_axi_arlen !== pv_arlen))
                note_viol($sformatf("AR changed while stalled at cycle %0d", cyc));
            if (pv_tvalid && !pv_tready && (bus_if.m_axis_tvalid !== 1'b1 ||
                bus_if.m_axis_tdata !== pv_tdata || bus_if.m_axis_tuser !== pv_tuser ||
                bus_if.m_axis_tlast !== pv_tlast))
                note_viol($sformatf("pixel changed while stalled at cycle %0d", cyc));
            if (bus_if.m_axi_arvalid === 1'b1) begin
                if (first_ar_cyc < 0) first_ar_cyc = cyc;
                if (int'(FD) - occ - outst < int'(bus_if.m_axi_arlen) + 1)
                    note_viol($sformatf("arvalid with credit %0d for len %0d",
                        int'(FD) - occ - outst, bus_if.m_axi_arlen));
                if (bus_if.m_axi_arid !== '0 || bus_if.m_axi_arsize !== 3'd3 ||
                    bus_if.m_axi_arburst !== 2'd1)
                    note_viol("AR id/size/burst not constant");
            end
            if (frame_done === 1'b1) begin
                done_cyc = cyc;
                done_err = rresp_err;
                drive_idle();
                start = spam;
                break;
            end

            bus_if.m_axi_arready = (cyc <= ar_hold) ? 1'b0 :
                                   (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
            if (!r_pend && rq_addr.size() > 0 && (!rnd || $urandom_range(0, 2) != 0))
                r_pend = 1'b1;
            if (r_pend) begin
                bus_if.m_axi_rvalid = 1'b1;
                bus_if.m_axi_rdata  = beat_fn(rq_addr[0]);
                bus_if.m_axi_rlast  = rq_last[0];
                bus_if.m_axi_rresp  = (rbeat == err_beat) ? 2'b10 : 2'b00;
            end else begin
                bus_if.m_axi_rvalid = 1'b0;
                bus_if.m_axi_rdata  = {$urandom, $urandom};
                bus_if.m_axi_rlast  = 1'b0;
                bus_if.m_axi_rresp  = 2'b00;
            end
            case (tr_mode)
                0:       bus_if.m_axis_tready = 1'b1;
                1:       bus_if.m_axis_tready = ($urandom_range(0, 3) != 0);
                default: bus_if.m_axis_tready = (cyc % 3 == 0);
            endcase

            ar_hs = bus_if.m_axi_arvalid && bus_if.m_axi_arready;
            r_hs  = r_pend && bus_if.m_axi_rready;
            t_hs  = bus_if.m_axis_tvalid && bus_if.m_axis_tready;
            if (ar_hs) begin
                got_ar_addr.push_back(bus_if.m_axi_araddr);
                got_ar_len.push_back(bus_if.m_axi_arlen);
                for (int b = 0; b <= int'(bus_if.m_axi_arlen); b++) begin
                    rq_addr.push_back(bus_if.m_axi_araddr + AW'(8 * b));
                    rq_last.push_back(b == int'(bus_if.m_axi_arlen));
                end
                outst += int'(bus_if.m_axi_arlen) + 1;
            end
            if (r_hs) begin
                void'(rq_addr.pop_front());
                void'(rq_last.pop_front());
                r_pend = 1'b0;
                occ++;
                outst--;
                if (rbeat == err_beat) exp_err = 1'b1;
                rbeat++;
            end
            if (t_hs) begin
                got_pix.push_back(bus_if.m_axis_tdata);
                got_user.push_back(bus_if.m_axis_tuser);
                got_last.push_back(bus_if.m_axis_tlast);
                if (npix % 2 == 1) occ--;
                npix++;
                last_hs_cyc = cyc;
            end
            pv_arvalid = bus_if.m_axi_arvalid; pv_arready = bus_if.m_axi_arready;
            pv_araddr = bus_if.m_axi_araddr; pv_arlen = bus_if.m_axi_arlen;
            pv_tvalid = bus_if.m_axis_tvalid; pv_tready = bus_if.m_axis_tready;
            pv_tdata = bus_if.m_axis_tdata; pv_tuser = bus_if.m_axis_tuser;
            pv_tlast = bus_if.m_axis_tlast;
            if (abort_pix >= 0 && npix >= abort_pix) break;
        end
    endtask

    task automatic test_reset();
        logic [9:0] obs;
        rst = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        obs = {busy, frame_done, rresp_err, bus_if.m_axi_arvalid, bus_if.m_axi_rready,
               bus_if.m_axis_tvalid, bus_if.m_axis_tuser, bus_if.m_axis_tlast,
               |bus_if.m_axi_araddr, |bus_if.m_axi_arlen};
        checks++;
        if (obs !== 10'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000000000", obs);
        end
        checks++;
        if ({bus_if.m_axi_arid, bus_if.m_axi_arsize, bus_if.m_axi_arburst} !== {4'd0, 3'd3, 2'd1}) begin
            errors++;
            $display("FAIL ar_constants: got id %0d size %0d burst %0d want 0/3/1",
                bus_if.m_axi_arid, bus_if.m_axi_arsize, bus_if.m_axi_arburst);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy got %b want 0", busy);
        end
    endtask

    task automatic test_basic();
        int m;
        string s;
        run_frame(28'h105, 0, 0, -1, -1, 1'b0, 1'b0);
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL basic_protocol: got %0d violations want 0 (%s)", viol, viol_msg); end
        m = pix_mism(28'h105, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL basic_pixels: got %0d bad want 0 (%s)", m, s); end
        m = ar_mism(28'h105, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL basic_bursts: got %0d bad want 0 (%s)", m, s); end
        checks++;
        if (first_ar_cyc !== 1) begin errors++; $display("FAIL first_ar_latency: got %0d want 1", first_ar_cyc); end
        checks++;
        if (done_cyc !== last_hs_cyc + 1) begin
            errors++;
            $display("FAIL frame_done_timing: got cycle %0d want %0d", done_cyc, last_hs_cyc + 1);
        end
        @(negedge clk);
        checks++;
        if ({busy, frame_done} !== 2'b00) begin
            errors++;
            $display("FAIL done_one_cycle: got busy/done %b want 00", {busy, frame_done});
        end
    endtask

    task automatic test_backpressure();
        int m;
        string s;
        logic [AW-1:0] b;
        b = AW'($urandom) & ~AW'(7);
        run_frame(b, 2, 0, -1, -1, 1'b0, 1'b1);
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL backpressure_protocol: got %0d violations want 0 (%s)", viol, viol_msg); end
        m = pix_mism(b, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL backpressure_pixels: got %0d bad want 0 (%s)", m, s); end
        m = ar_mism(b, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL backpressure_bursts: got %0d bad want 0 (%s)", m, s); end
        @(negedge clk);
    endtask

    task automatic test_ar_stall();
        int m;
        string s;
        logic [AW-1:0] b;
        b = 28'h0002340;
        run_frame(b, 1, 10, -1, -1, 1'b1, 1'b1);
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL ar_stall_protocol: got %0d violations want 0 (%s)", viol, viol_msg); end
        m = ar_mism(b, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL ar_stall_bursts: got %0d bad want 0 (%s)", m, s); end
        m = pix_mism(b, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL ar_stall_pixels: got %0d bad want 0 (%s)", m, s); end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_in_done_ignored: busy got %b want 0", busy); end
        @(negedge clk);
    endtask

    task automatic test_rresp_err();
        int m;
        string s;
        run_frame(28'h0400, 1, 0, 1, -1, 1'b0, 1'b1);
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL rresp_protocol: got %0d violations want 0 (%s)", viol, viol_msg); end
        checks++;
        if (done_err !== 1'b1) begin errors++; $display("FAIL rresp_sticky: got %b want 1", done_err); end
        m = pix_mism(28'h0400, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL rresp_pixels: got %0d bad want 0 (%s)", m, s); end
        @(negedge clk);
        run_frame(28'h0800, 0, 0, -1, -1, 1'b0, 1'b1);
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL rresp_clear_protocol: got %0d violations want 0 (%s)", viol, viol_msg); end
        checks++;
        if (done_err !== 1'b0) begin errors++; $display("FAIL rresp_cleared: got %b want 0", done_err); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int m;
        string s;
        run_frame(28'hFFFFFF8, 0, 0, -1, -1, 1'b0, 1'b1);
        m = ar_mism(28'hFFFFFF8, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL wrap_bursts: got %0d bad want 0 (%s)", m, s); end
        m = pix_mism(28'hFFFFFF8, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL wrap_pixels: got %0d bad want 0 (%s)", m, s); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [8:0] obs;
        int m;
        string s;
        run_frame(28'h0A00, 0, 0, -1, 3, 1'b0, 1'b1);
        checks++;
        if (got_pix.size() !== 3) begin errors++; $display("FAIL pre_abort_pixels: got %0d want 3", got_pix.size()); end
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        obs = {busy, frame_done, rresp_err, bus_if.m_axi_arvalid, bus_if.m_axi_rready,
               bus_if.m_axis_tvalid, bus_if.m_axis_tuser, bus_if.m_axis_tlast,
               |bus_if.m_axis_tdata};
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL mid_frame_reset: got %b want 000000000", obs); end
        rst = 1'b0;
        @(negedge clk);
        run_frame(28'h0C00, 1, 0, -1, -1, 1'b0, 1'b1);
        checks++;
        if (viol !== 0) begin errors++; $display("FAIL post_reset_protocol: got %0d violations want 0 (%s)", viol, viol_msg); end
        m = pix_mism(28'h0C00, s);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL post_reset_pixels: got %0d bad want 0 (%s)", m, s); end
        @(negedge clk);
    endtask

    task automatic test_random();
        int m;
        string s;
        logic [AW-1:0] b;
        for (int f = 0; f < 4; f++) begin
            b = AW'($urandom);
            seed = 24'($urandom);
            run_frame(b, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1, -1, 1'b0, 1'b1);
            checks++;
            if (viol !== 0) begin errors++; $display("FAIL random_protocol_%0d: got %0d violations want 0 (%s)", f, viol, viol_msg); end
            m = pix_mism(b, s);
            checks++;
            if (m !== 0) begin errors++; $display("FAIL random_pixels_%0d: got %0d bad want 0 (%s)", f, m, s); end
            m = ar_mism(b, s);
            checks++;
            if (m !== 0) begin errors++; $display("FAIL random_bursts_%0d: got %0d bad want 0 (%s)", f, m, s); end
            @(negedge clk);
        end
    endtask

    initial begin
        drive_idle();
        seed = 24'($urandom);
        test_reset();
        test_basic();
        test_backpressure();
        test_ar_stall();
        test_rresp_err();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_scanout_axis_src.md
Name: fb_scanout_axis_src

Overview:
AXI4 read master that scans a packed framebuffer out of SDRAM and emits one frame of 24-bit RGB pixels on an AXI-Stream master port. It is the source-side counterpart to the HDMI stream sink and the SDRAM slave already in the shell. Each 64-bit read beat carries two 32-bit pixel words, low word first; RGB is bits [23:0] of each word. It has a credit-limited burst issuer, a beat FIFO, and a pixel unpacker, and is started per frame by a CSR pulse.

Parameters:
SCREEN_WIDTH, 480, pixels per line
SCREEN_HEIGHT, 360, lines per frame; TOTAL_PIXELS = SCREEN_WIDTH*SCREEN_HEIGHT, must be even
ADDR_WIDTH, 28, AXI address width
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant ARID value
BURST_LEN, 16, max beats per AR burst (power of 2, 1..256)
FIFO_DEPTH, 64, beat FIFO entries (power of 2, >= BURST_LEN)

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begin a frame; ignored while busy
base_addr  in  ADDR_WIDTH  frame base byte address; sampled on accepted start; bits [2:0] forced to 0
busy  out  1  high from accepted start through the frame_done cycle
frame_done  out  1  one-cycle pulse when the last pixel handshakes
rresp_err  out  1  sticky; set on any RRESP!=0; cleared by accepted start or rst
m_axi_arid  out  ID_WIDTH  constant AXI_ID
m_axi_araddr  out  ADDR_WIDTH  burst byte address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  constant 3 (8 bytes)
m_axi_arburst  out  2  constant 1 (INCR)
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  ID_WIDTH  ignored
m_axi_rdata  in  64  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  ignored for counting; beats are counted internally
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axis_tdata  out  24  RGB pixel
m_axis_tvalid  out  1  pixel valid
m_axis_tlast  out  1  high on pixel TOTAL_PIXELS-1 (end of frame)
m_axis_tuser  out  1  high on pixel 0 (start of frame)
m_axis_tready  in  1  sink ready

Behaviour:
- Reset (rst sampled high at clk edge): FSM=IDLE; FIFO empty; all counters 0; arvalid, rready, tvalid, tlast, tuser, busy, frame_done and rresp_err all 0; araddr and arlen 0. Reset mid-frame aborts immediately with no AR/R completion. The bench must reset the slave in the same cycle.
- TOTAL_BEATS = TOTAL_PIXELS/2.
- FSM IDLE -> RUN on start. RUN -> DRAIN when the last AR handshakes. DRAIN -> DONE when the last pixel handshakes. DONE lasts 1 cycle: frame_done=1, busy still 1. DONE -> IDLE. A start pulse in DONE is ignored.
- AR issuer, active in RUN only:
  - burst beats = min(BURST_LEN, beats_remaining_to_request).
  - arvalid asserts only if FIFO free entries minus beats outstanding >= burst beats. This is the credit rule; the FIFO can never overflow.
  - Once arvalid is asserted, it and araddr/arlen hold stable until arready.
  - On AR handshake: araddr += 8*beats, outstanding += beats.
  - First araddr = base_addr. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- R path:
  - rready = 1 whenever busy and outstanding > 0. Credit guarantees space for every such beat.
  - On R handshake: push rdata, outstanding -= 1, and OR (rresp!=0) into rresp_err. Data is passed regardless of rresp.
  - If an AR handshake and an R handshake fall in the same cycle, outstanding changes by +beats-1.
- Unpacker:
  - The head beat yields pixel lo = rdata[23:0], then hi = rdata[55:32]. The FIFO pops after the hi pixel handshakes.
  - tvalid = 1 whenever the FIFO is non-empty in RUN/DRAIN.
  - tdata/tuser/tlast hold stable while tvalid & !tready.
  - pixel_cnt increments on each handshake. tuser = (pixel_cnt==0); tlast = (pixel_cnt==TOTAL_PIXELS-1).
- Simultaneous FIFO push and pop in one cycle is supported with no bubble.
- Sustained throughput: 1 pixel/clk with tready=1, given slave R bandwidth of at least 0.5 beat/clk.
- First-pixel latency: 1 cycle after start to arvalid; the first tvalid appears the cycle after the first R handshake.

Test Plan:
- W=4,H=2,BURST_LEN=2, base=0x100, memory words 0..3 = {hi=0x00A0B0C0+i, lo=0x00102030+i}, tready=1 -> AR (0x100,len1),(0x110,len1); pixels 0x102030,0xA0B0C0,0x102031,... 8 total; tuser on pixel 0, tlast on pixel 7; frame_done 1 cycle after tlast handshake.
- Same setup, but W=6,H=1 (3 beats) -> second burst arlen=0 at 0x110; 6 pixels.
- tready toggling 1-of-3 cycles, FIFO_DEPTH=4, BURST_LEN=2 -> arvalid never asserts when credit < 2; no lost or duplicated pixel; tdata stable while stalled.
- arready held 0 for 10 cycles -> arvalid, araddr and arlen hold stable; start pulses during busy are ignored.
- Slave returns SLVERR on beat 1 -> rresp_err=1 after that beat, pixels still emitted; next start clears it.
- rst asserted mid-frame after 3 pixels -> all outputs 0 the next cycle; a new start gives a full frame from pixel 0 with tuser.
